// File: rtl/mem_rd_arbiter_pkg.sv
// mem_rd_arbiter_pkg: FSM encoding, AXI constants and the arbitration rule shared by the read arbiter.
package mem_rd_arbiter_pkg;
    typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_ADDR = 2'd1, ARB_DATA = 2'd2} arb_state_t;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    // A lone requester wins; a tie goes to master 0 under fixed priority, else to the one not served last.
    function automatic logic arb_pick(input logic [1:0] req, input logic last_grant, input logic fixed_prio);
        return (req == 2'b11) ? (fixed_prio ? 1'b0 : !last_grant) : req[1];
    endfunction
endpackage

// File: rtl/mem_rd_arb_rr.sv
// mem_rd_arb_rr: combinational two-way round-robin / fixed-priority pick.
module mem_rd_arb_rr
    import mem_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       gnt_valid,
    output logic       gnt_id
);
    assign gnt_valid = |req;
    assign gnt_id    = arb_pick(req, last_grant, fixed_prio);
endmodule

// File: rtl/mem_rd_arbiter.sv
// mem_rd_arbiter: two-master AXI4 read-channel arbiter, one whole burst per grant.
// Optional per-master grant and conflict counters when MEM_RD_ARB_STATS_EN is defined.
module mem_rd_arbiter
    import mem_rd_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fixed_prio,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic [2:0]            m0_arprot,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    output logic                  m0_rlast,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic [2:0]            m1_arprot,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic                  m1_rlast,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    output logic [2:0]            s_arprot,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [1:0]            s_rresp,
    input  logic                  s_rlast,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic                  grant_id,
    output logic                  busy
`ifdef MEM_RD_ARB_STATS_EN
    ,
    output logic [31:0]           stat_grants0,
    output logic [31:0]           stat_grants1,
    output logic [31:0]           stat_conflicts
`endif
);
    arb_state_t state, state_nxt;
    logic last_grant, gnt_valid, gnt_id;
    logic ar_hs, r_done, r0_sel, r1_sel, grant_now;

    mem_rd_arb_rr u_rr (
        .req        ({m1_arvalid, m0_arvalid}),
        .last_grant (last_grant),
        .fixed_prio (fixed_prio),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign grant_now = (state == ARB_IDLE) && gnt_valid;
    assign ar_hs     = s_arvalid && s_arready;
    assign r_done    = s_rvalid && s_rready && s_rlast;
    assign r0_sel    = (state == ARB_DATA) && !grant_id;
    assign r1_sel    = (state == ARB_DATA) && grant_id;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = grant_now                         ? ARB_ADDR :
                    (state == ARB_ADDR && ar_hs)      ? ARB_DATA :
                    (state == ARB_DATA && r_done)     ? ARB_IDLE : state;
    end

    // The winner's payload is frozen here so the slave sees it stable while arready is low.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            s_araddr   <= '0;
            s_arlen    <= '0;
            s_arsize   <= '0;
            s_arburst  <= '0;
            s_arprot   <= '0;
        end else if (grant_now) begin
            last_grant <= gnt_id;
            grant_id   <= gnt_id;
            s_araddr   <= gnt_id ? m1_araddr  : m0_araddr;
            s_arlen    <= gnt_id ? m1_arlen   : m0_arlen;
            s_arsize   <= gnt_id ? m1_arsize  : m0_arsize;
            s_arburst  <= gnt_id ? m1_arburst : m0_arburst;
            s_arprot   <= gnt_id ? m1_arprot  : m0_arprot;
        end

    always_comb begin
        s_arvalid  = (state == ARB_ADDR);
        busy       = (state != ARB_IDLE);
        m0_arready = s_arvalid && !grant_id && s_arready;
        m1_arready = s_arvalid && grant_id && s_arready;
        s_rready   = (state == ARB_DATA) && (grant_id ? m1_rready : m0_rready);
        m0_rvalid  = r0_sel && s_rvalid;
        m0_rdata   = r0_sel ? s_rdata : '0;
        m0_rresp   = r0_sel ? s_rresp : '0;
        m0_rlast   = r0_sel && s_rlast;
        m1_rvalid  = r1_sel && s_rvalid;
        m1_rdata   = r1_sel ? s_rdata : '0;
        m1_rresp   = r1_sel ? s_rresp : '0;
        m1_rlast   = r1_sel && s_rlast;
    end

`ifdef MEM_RD_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stat_grants0   <= '0;
            stat_grants1   <= '0;
            stat_conflicts <= '0;
        end else begin
            if (ar_hs && !grant_id) stat_grants0 <= stat_grants0 + 32'd1;
            if (ar_hs && grant_id) stat_grants1 <= stat_grants1 + 32'd1;
            if (grant_now && m0_arvalid && m1_arvalid) stat_conflicts <= stat_conflicts + 32'd1;
        end
`endif
endmodule

// File: tb/tb_mem_rd_arbiter.sv
// tb_mem_rd_arbiter: random two-master traffic against a transaction-level arbitration model with AR/R scoreboards.
module tb_mem_rd_arbiter;
    import mem_rd_arbiter_pkg::*;

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [2:0]  prot;
    } ar_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0, rst = 1'b1, fixed_prio = 1'b0;
    logic [1:0][31:0] araddr, rdata;
    logic [1:0][7:0]  arlen;
    logic [1:0][2:0]  arsize, arprot;
    logic [1:0][1:0]  arburst, rresp;
    logic [1:0]       arvalid, arready, rvalid, rlast, rready;
    logic [31:0] s_araddr, s_rdata;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize, s_arprot;
    logic [1:0]  s_arburst, s_rresp;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, grant_id, busy;
`ifdef MEM_RD_ARB_STATS_EN
    logic [31:0] stat_grants0, stat_grants1, stat_conflicts;
`endif

    mem_rd_arbiter dut (
        .clk(clk), .rst(rst), .fixed_prio(fixed_prio),
        .m0_araddr(araddr[0]), .m0_arlen(arlen[0]), .m0_arsize(arsize[0]), .m0_arburst(arburst[0]),
        .m0_arprot(arprot[0]), .m0_arvalid(arvalid[0]), .m0_arready(arready[0]),
        .m0_rdata(rdata[0]), .m0_rresp(rresp[0]), .m0_rlast(rlast[0]), .m0_rvalid(rvalid[0]), .m0_rready(rready[0]),
        .m1_araddr(araddr[1]), .m1_arlen(arlen[1]), .m1_arsize(arsize[1]), .m1_arburst(arburst[1]),
        .m1_arprot(arprot[1]), .m1_arvalid(arvalid[1]), .m1_arready(arready[1]),
        .m1_rdata(rdata[1]), .m1_rresp(rresp[1]), .m1_rlast(rlast[1]), .m1_rvalid(rvalid[1]), .m1_rready(rready[1]),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant_id(grant_id), .busy(busy)
`ifdef MEM_RD_ARB_STATS_EN
        , .stat_grants0(stat_grants0), .stat_grants1(stat_grants1), .stat_conflicts(stat_conflicts)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int p0, p1, prr, psar;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got an event, required none at %0t", name, $time);
    endtask

    // Slave memory content: data and response are pure functions of burst address and beat index.
    function automatic logic [31:0] bdata(input logic [31:0] a, input logic [7:0] b);
        return (a ^ {b, 24'h5A_C3E1}) + 32'h0001_2345 * {24'd0, b};
    endfunction
    function automatic logic [1:0] bresp(input logic [31:0] a, input logic [7:0] b);
        return a[5:4] + b[1:0];
    endfunction

    function automatic logic winner(input logic [1:0] v, input logic fp, input logic last);
        if (!v[0]) return 1'b1;
        if (!v[1]) return 1'b0;
        if (fp) return 1'b0;
        return last ? 1'b0 : 1'b1;
    endfunction

    function automatic ar_t pay(input logic i);
        return {i, araddr[i], arlen[i], arsize[i], arburst[i], arprot[i]};
    endfunction

    // Reference model: which burst the shared port is serving and in which phase.
    logic [1:0] ph;
    logic       mg, mlast;
    ar_t        mpay;
    ar_t        exp_ar[$];
    beat_t      exp_r0[$], exp_r1[$];
    int         n_g0, n_g1, n_conf;

    always @(posedge clk) begin
        if (rst) begin
            ph <= 2'd0; mg <= 1'b0; mlast <= 1'b1; mpay <= '0;
            n_g0 <= 0; n_g1 <= 0; n_conf <= 0;
            exp_ar.delete(); exp_r0.delete(); exp_r1.delete();
        end else if (ph == 2'd0 && arvalid != 2'b00) begin
            exp_ar.push_back(pay(winner(arvalid, fixed_prio, mlast)));
            mpay  <= pay(winner(arvalid, fixed_prio, mlast));
            mg    <= winner(arvalid, fixed_prio, mlast);
            mlast <= winner(arvalid, fixed_prio, mlast);
            ph    <= 2'd1;
            if (arvalid == 2'b11) n_conf <= n_conf + 1;
        end else if (ph == 2'd1 && s_arready) begin
            ph <= 2'd2;
            for (int b = 0; b <= int'(mpay.len); b++)
                if (mpay.id) exp_r1.push_back({bdata(mpay.addr, 8'(b)), bresp(mpay.addr, 8'(b)), b == int'(mpay.len)});
                else         exp_r0.push_back({bdata(mpay.addr, 8'(b)), bresp(mpay.addr, 8'(b)), b == int'(mpay.len)});
            if (mpay.id) n_g1 <= n_g1 + 1;
            else         n_g0 <= n_g0 + 1;
        end else if (ph == 2'd2 && s_rvalid && s_rlast && rready[mg]) begin
            ph <= 2'd0;
        end
    end

    // Master and slave bookkeeping used by the stimulus driver.
    logic [1:0] ahs, outst;
    logic       shs, sl_act;
    logic [31:0] sl_addr;
    logic [7:0]  sl_len, sl_beat;

    always @(posedge clk) begin
        if (rst) begin
            ahs <= 2'b00; outst <= 2'b00; shs <= 1'b0; sl_act <= 1'b0;
            sl_addr <= '0; sl_len <= '0; sl_beat <= '0;
        end else begin
            ahs <= arvalid & arready;
            for (int i = 0; i < 2; i++)
                if (arvalid[i] && arready[i]) outst[i] <= 1'b1;
                else if (rvalid[i] && rready[i] && rlast[i]) outst[i] <= 1'b0;
            shs <= s_rvalid && s_rready;
            if (s_arvalid && s_arready) begin
                sl_act <= 1'b1; sl_addr <= s_araddr; sl_len <= s_arlen; sl_beat <= 8'd0;
            end
            if (s_rvalid && s_rready) begin
                sl_beat <= sl_beat + 8'd1;
                if (s_rlast) sl_act <= 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    always @(posedge clk) begin
        if (!rst) begin
            if (s_arvalid && s_arready) begin
                if (exp_ar.size() == 0) fail("ar_unexpected");
                else chk("ar", {grant_id, s_araddr, s_arlen, s_arsize, s_arburst, s_arprot}, exp_ar.pop_front());
            end
            if (rvalid[0] && rready[0]) begin
                if (exp_r0.size() == 0) fail("r0_unexpected");
                else chk("r0_beat", {rdata[0], rresp[0], rlast[0]}, exp_r0.pop_front());
            end
            if (rvalid[1] && rready[1]) begin
                if (exp_r1.size() == 0) fail("r1_unexpected");
                else chk("r1_beat", {rdata[1], rresp[1], rlast[1]}, exp_r1.pop_front());
            end
        end
    end

    task automatic check_cycle();
        logic [1:0] ea, ev;
        ea = (ph == 2'd1) ? (mg ? {s_arready, 1'b0} : {1'b0, s_arready}) : 2'b00;
        ev = (ph == 2'd2) ? (mg ? {s_rvalid, 1'b0} : {1'b0, s_rvalid}) : 2'b00;
        chk("ctl", {busy, s_arvalid, grant_id, arready, s_rready, rvalid},
            {ph != 2'd0, ph == 2'd1, mg, ea, (ph == 2'd2) && rready[mg], ev});
        chk("other_r", {rdata[!mg], rresp[!mg], rlast[!mg]}, '0);
        if (ph == 2'd1) chk("ar_hold", {grant_id, s_araddr, s_arlen, s_arsize, s_arburst, s_arprot}, mpay);
    endtask

    task automatic new_req(input int i, input logic [31:0] a, input logic [7:0] l);
        arvalid[i] = 1'b1; araddr[i] = a; arlen[i] = l; arsize[i] = 3'd2;
        arburst[i] = AXI_BURST_INCR; arprot[i] = 3'($urandom_range(7));
    endtask

    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (ahs[i]) arvalid[i] = 1'b0;
            if (!arvalid[i] && !outst[i] && $urandom_range(99) < (i == 0 ? p0 : p1))
                new_req(i, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(7)));
            rready[i] = $urandom_range(99) < prr;
        end
        s_arready = $urandom_range(99) < psar;
        if (!s_rvalid || shs) s_rvalid = sl_act && ($urandom_range(3) != 0);
        s_rdata = bdata(sl_addr, sl_beat);
        s_rresp = bresp(sl_addr, sl_beat);
        s_rlast = (sl_beat == sl_len);
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_inputs();
        arvalid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arprot = '0; rready = '0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
    endtask

    initial begin
        bit seen;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {busy, s_arvalid, grant_id, arready, s_rready, rvalid}, '0);
        chk("rst_ar", {s_araddr, s_arlen, s_arsize, s_arburst, s_arprot}, '0);
        chk("rst_r", {rdata, rresp, rlast}, '0);
        rst = 1'b0;
        // Lone master 0, directed first burst.
        new_req(0, 32'h0000_1000, 8'd3);
        @(negedge clk);
        chk("first_ar", {s_arvalid, grant_id, s_araddr}, {1'b1, 1'b0, 32'h0000_1000});
        p0 = 60; p1 = 0; prr = 80; psar = 90; fixed_prio = 1'b0;
        run(300);
        p0 = 50; p1 = 50;
        run(1500);
        p0 = 100; p1 = 80; fixed_prio = 1'b1;
        run(1000);
        p0 = 70; p1 = 70; prr = 40; psar = 15; fixed_prio = 1'b0;
        run(1500);
        // Reset in the middle of a data phase.
        prr = 30; psar = 90; seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            seen = (ph == 2'd2);
        end
        if (!seen) fail("wait_data_timeout");
        rst = 1'b1;
        #1;
        chk("mid_rst", {busy, s_arvalid, arready, s_rready, rvalid}, '0);
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        new_req(0, 32'h0000_2000, 8'd1);
        new_req(1, 32'h0000_3000, 8'd2);
        @(negedge clk);
        chk("tie_after_rst", {s_arvalid, grant_id, s_araddr}, {1'b1, 1'b0, 32'h0000_2000});
        p0 = 60; p1 = 60; prr = 70;
        run(800);
        p0 = 0; p1 = 0; prr = 100; psar = 100;
        for (int k = 0; k < 1000 && !(ph == 2'd0 && arvalid == 2'b00 && exp_ar.size() == 0 &&
                                       exp_r0.size() == 0 && exp_r1.size() == 0); k++)
            step();
        if (!(ph == 2'd0 && exp_ar.size() == 0 && exp_r0.size() == 0 && exp_r1.size() == 0))
            fail("drain_timeout");
`ifdef MEM_RD_ARB_STATS_EN
        chk("stat_grants0", stat_grants0, n_g0);
        chk("stat_grants1", stat_grants1, n_g1);
        chk("stat_conflicts", stat_conflicts, n_conf);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
